// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: hex decode, per-digit dp, leading-zero
// blanking, frame-synchronous buffer updates. Per-digit blinking when SEG_BLINK_EN is defined.
module seg_scan_ctrl #(
  parameter int DIGITS         = 6,
  parameter int SCAN_DIV       = 10000,
  parameter int BLINK_DIV      = 250,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   num,
  input  logic [DIGITS-1:0]     point,
  input  logic                  load,
  input  logic                  en,
  input  logic                  lz_blank,
  input  logic [DIGITS-1:0]     blink,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg_led,
  output logic                  frame_done
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = $clog2(DIGITS);

  localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{SEL_ACTIVE_LOW != 0}};
  localparam logic [7:0]        SEG_OFF = {8{SEG_ACTIVE_LOW != 0}};

  logic [SCAN_W-1:0]   scan_cnt;
  logic [IDX_W-1:0]    idx;
  logic                tick;
  logic                wrap;

  logic [4*DIGITS-1:0] active_num;
  logic [DIGITS-1:0]   active_pt;
  logic [4*DIGITS-1:0] pend_num;
  logic [DIGITS-1:0]   pend_pt;
  logic                pend_flag;

  logic [DIGITS-1:0]   lz_mask;
  logic [DIGITS-1:0]   blink_mask;

  logic [3:0]          cur_nib;
  logic                cur_pt;
  logic                cur_blank;
  logic [7:0]          seg_on;
  logic [DIGITS-1:0]   sel_on;

  // Logical pattern g..a, 0 = segment on.
  function automatic logic [6:0] hex_pattern(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0:    p = 7'b1000000;
      4'h1:    p = 7'b1111001;
      4'h2:    p = 7'b0100100;
      4'h3:    p = 7'b0110000;
      4'h4:    p = 7'b0011001;
      4'h5:    p = 7'b0010010;
      4'h6:    p = 7'b0000010;
      4'h7:    p = 7'b1111000;
      4'h8:    p = 7'b0000000;
      4'h9:    p = 7'b0010000;
      4'hA:    p = 7'b0001000;
      4'hB:    p = 7'b0000011;
      4'hC:    p = 7'b1000110;
      4'hD:    p = 7'b0100001;
      4'hE:    p = 7'b0000110;
      default: p = 7'b0001110;
    endcase
    return p;
  endfunction

  assign tick = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign wrap = tick && (idx == IDX_W'(DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (tick) begin
      scan_cnt <= '0;
      idx      <= wrap ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // A load coinciding with the frame boundary bypasses pending so it is shown
  // in the frame that starts right there; it also supersedes any older pending value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_num <= '0;
      active_pt  <= '0;
      pend_num   <= '0;
      pend_pt    <= '0;
      pend_flag  <= 1'b0;
    end else if (load && wrap) begin
      active_num <= num;
      active_pt  <= point;
      pend_flag  <= 1'b0;
    end else if (load) begin
      pend_num   <= num;
      pend_pt    <= point;
      pend_flag  <= 1'b1;
    end else if (wrap && pend_flag) begin
      active_num <= pend_num;
      active_pt  <= pend_pt;
      pend_flag  <= 1'b0;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLK_W-1:0] frame_cnt;
  logic             blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      if (frame_cnt == BLK_W'(BLINK_DIV - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt   <= frame_cnt + 1'b1;
      end
    end
  end

  assign blink_mask = blink_phase ? blink : '0;
`else
  logic unused_blink_cfg;

  assign blink_mask       = '0;
  assign unused_blink_cfg = ^{blink, 1'(BLINK_DIV % 2)};
`endif

  // Walk down from the top digit; blanking stops at the first digit showing
  // anything (non-zero value or a lit dp). Digit 0 always shows.
  always_comb begin
    logic lead;
    lead    = 1'b1;
    lz_mask = '0;
    for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
      if (active_num[4*k +: 4] != 4'h0 || active_pt[k])
        lead = 1'b0;
      lz_mask[k] = lead & lz_blank;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_pt    = 1'b0;
    cur_blank = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = active_num[4*i +: 4];
        cur_pt    = active_pt[i];
        cur_blank = lz_mask[i] | blink_mask[i];
      end
    end
    seg_on = cur_blank ? 8'h00 : {cur_pt, ~hex_pattern(cur_nib)};
    sel_on = DIGITS'(1) << idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel        <= SEL_OFF;
      seg_led    <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (en) begin
        sel     <= sel_on ^ SEL_OFF;
        seg_led <= seg_on ^ SEG_OFF;
      end else begin
        sel     <= SEL_OFF;
        seg_led <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-level reference model predicts each
// output cycle; a monitor pops and compares. Directed checks cover the board test plan.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;
  localparam int D     = 6;
  localparam int S     = 4;
  localparam int BD    = 2;
  localparam int FRAME = D * S;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4*D-1:0] num = '0;
  logic [D-1:0] point = '0;
  logic [D-1:0] blink = '0;
  logic         load = 1'b0;
  logic         en = 1'b1;
  logic         lz_blank = 1'b0;
  logic [D-1:0] sel;
  logic [7:0]   seg_led;
  logic         frame_done;

  int checks = 0;
  int errors = 0;
  int unsigned t = 0;

  typedef struct {
    int unsigned    at;
    logic [4*D-1:0] n;
    logic [D-1:0]   p;
  } load_t;

  typedef struct {
    int unsigned  t;
    logic [D-1:0] sel;
    logic [7:0]   seg;
    logic         fd;
  } exp_t;

  load_t loads[$];
  exp_t  exp_q[$];

  logic [6:0] dec [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seg_scan_ctrl #(
    .DIGITS(D),
    .SCAN_DIV(S),
    .BLINK_DIV(BD),
    .SEL_ACTIVE_LOW(1),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .num(num),
    .point(point),
    .load(load),
    .en(en),
    .lz_blank(lz_blank),
    .blink(blink),
    .sel(sel),
    .seg_led(seg_led),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output after edge tt (tt>=1 since reset release): digit ((tt-1)/S)%D of
  // frame (tt-1)/FRAME, showing the last value loaded at or before that frame's start edge.
  function automatic exp_t ref_out(input int unsigned tt, input logic e, input logic lz);
    exp_t           r;
    int unsigned    d, f, start;
    logic [4*D-1:0] n;
    logic [D-1:0]   p;
    logic           blank;
    d     = ((tt - 1) / S) % D;
    f     = (tt - 1) / FRAME;
    start = f * FRAME;
    n = '0;
    p = '0;
    foreach (loads[k])
      if (loads[k].at <= start) begin
        n = loads[k].n;
        p = loads[k].p;
      end
    blank = 1'b0;
    if (lz && d != 0) begin
      blank = 1'b1;
      for (int j = d; j < D; j++)
        if (n[4*j +: 4] != 4'h0 || p[j]) blank = 1'b0;
    end
`ifdef SEG_BLINK_EN
    if (blink[d] && ((f / BD) % 2 == 1)) blank = 1'b1;
`endif
    r.t  = tt;
    r.fd = (tt % FRAME == 0);
    if (!e) begin
      r.sel = '1;
      r.seg = 8'hFF;
    end else begin
      r.sel = ~(D'(1) << d);
      r.seg = blank ? 8'hFF : {~p[d], dec[n[4*d +: 4]]};
    end
    return r;
  endfunction

  initial begin : model
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        t = 0;
        loads.delete();
        exp_q.push_back('{0, '1, 8'hFF, 1'b0});
      end else begin
        t++;
        if (load) loads.push_back('{t, num, point});
        exp_q.push_back(ref_out(t, en, lz_blank));
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got no expectation required one");
      end else begin
        e = exp_q.pop_front();
        check($sformatf("sel@t%0d", e.t), 32'(sel), 32'(e.sel));
        check($sformatf("seg@t%0d", e.t), 32'(seg_led), 32'(e.seg));
        check($sformatf("fd@t%0d", e.t), 32'(frame_done), 32'(e.fd));
      end
    end
  end

  task automatic wait_fd(input string name);
    bit found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(posedge clk);
      #2;
      if (frame_done) found = 1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s: got no frame_done required pulse within %0d cycles", name, 2 * FRAME);
    end
  endtask

  task automatic expect_digit(input logic [D-1:0] target, input logic [7:0] exp_seg, input string name);
    bit found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(posedge clk);
      #2;
      if (sel == target) found = 1;
    end
    if (found) check(name, 32'(seg_led), 32'(exp_seg));
    else begin
      checks++;
      errors++;
      $display("FAIL %s: got sel never %0h required within %0d cycles", name, target, 2 * FRAME);
    end
  endtask

  task automatic do_load(input logic [4*D-1:0] n, input logic [D-1:0] p);
    @(negedge clk);
    num   = n;
    point = p;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin : stim
    int fd_cnt, dark, shown;
    bit hit;

    repeat (2) @(negedge clk);
    check("rst_sel", 32'(sel), 32'h3F);
    check("rst_seg", 32'(seg_led), 32'hFF);
    check("rst_fd", 32'(frame_done), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("first_sel", 32'(sel), 32'h3E);
    check("first_seg", 32'(seg_led), 32'hC0);

    do_load(24'h123456, 6'b000100);
    wait_fd("fd_123456");
    expect_digit(6'b111110, 8'h82, "d0_six");
    expect_digit(6'b111011, 8'h19, "d2_four_dp");

    @(negedge clk);
    lz_blank = 1'b1;
    do_load(24'h000070, 6'b000000);
    wait_fd("fd_lz");
    expect_digit(6'b011111, 8'hFF, "lz_d5");
    expect_digit(6'b111011, 8'hFF, "lz_d2");
    expect_digit(6'b111101, 8'hF8, "lz_d1");
    expect_digit(6'b111110, 8'hC0, "lz_d0");

    do_load(24'h000000, 6'b000000);
    wait_fd("fd_zero");
    expect_digit(6'b111110, 8'hC0, "zero_d0");
    expect_digit(6'b111101, 8'hFF, "zero_d1");

    @(negedge clk);
    lz_blank = 1'b0;
    do_load(24'h00000F, 6'b000000);
    wait_fd("fd_hexf");
    expect_digit(6'b111110, 8'h8E, "hex_f");

    @(negedge clk);
    en = 1'b0;
    fd_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clk);
      #2;
      fd_cnt += int'(frame_done);
    end
    check("en0_fd_count", 32'(fd_cnt), 32'd2);
    @(negedge clk);
    en = 1'b1;

    // Load while digit 3 is on: digit 4 keeps the old value, next frame is new.
    wait_fd("fd_mid");
    repeat (3 * S) @(posedge clk);
    do_load(24'h999999, 6'b000000);
    expect_digit(6'b101111, 8'hC0, "mid_old_d4");
    wait_fd("fd_mid2");
    expect_digit(6'b111110, 8'h90, "mid_new_d0");

    @(negedge clk);
    hit = 0;
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      if (t % FRAME == FRAME - 1) hit = 1;
      else @(negedge clk);
    end
    num  = 24'h555555;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    expect_digit(6'b111110, 8'h92, "bnd_new_d0");

    blink = 6'b001000;
    do_load(24'h888888, 6'b000000);
    wait_fd("fd_blink");
    dark  = 0;
    shown = 0;
    for (int i = 0; i < 8 * FRAME; i++) begin
      @(posedge clk);
      #2;
      if (sel == 6'b110111) begin
        shown++;
        if (seg_led == 8'hFF) dark++;
      end
    end
    check("blink_d3_cycles", 32'(shown), 32'(8 * S));
`ifdef SEG_BLINK_EN
    check("blink_d3_dark", 32'(dark), 32'(4 * S));
`else
    check("blink_d3_dark", 32'(dark), 32'd0);
`endif

    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      en       = ($urandom_range(0, 3) != 0);
      lz_blank = $urandom_range(0, 1);
      blink    = D'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        num   = {$urandom_range(0, 1) ? 4'h0 : 4'($urandom), 4'($urandom), 20'($urandom)};
        point = $urandom_range(0, 1) ? '0 : D'($urandom);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
      end
      repeat ($urandom_range(1, 30)) @(negedge clk);
    end

    // Reset in mid-frame with a pending value that must be discarded.
    @(negedge clk);
    en       = 1'b1;
    lz_blank = 1'b0;
    blink    = '0;
    wait_fd("fd_pre_rst");
    repeat (S) @(posedge clk);
    do_load(24'h654321, 6'b111111);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_sel", 32'(sel), 32'h3F);
    check("async_rst_seg", 32'(seg_led), 32'hFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("rerst_sel", 32'(sel), 32'h3E);
    wait_fd("fd_post_rst");
    expect_digit(6'b111110, 8'hC0, "pend_discard_d0");

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed 7-segment scan controller: the next-generation display driver for the board's common-anode digit arrays. Drives DIGITS digits from a packed nibble bus with hex decode, per-digit decimal points, leading-zero blanking, frame-synchronous tear-free updates and optional per-digit blinking. Sits between the measurement/recognition datapath and the board's sel/seg_led pins.

## Interface
- DIGITS, 6, number of digits scanned (2..8)
- SCAN_DIV, 10000, clk cycles each digit is lit
- BLINK_DIV, 250, frames per blink half-period
- SEL_ACTIVE_LOW, 1, 1: digit select active-low
- SEG_ACTIVE_LOW, 1, 1: segments and dp active-low
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- num  in  4*DIGITS  digit values; nibble i drives digit i (digit 0 = rightmost)
- point  in  DIGITS  dp request per digit, 1 = lit
- load  in  1  capture num/point into pending buffer
- en  in  1  display enable; 0 = all digits dark
- lz_blank  in  1  blank leading zeros
- blink  in  DIGITS  per-digit blink enable
- sel  out  DIGITS  digit select, registered
- seg_led  out  8  {dp,g,f,e,d,c,b,a}, registered
- frame_done  out  1  one-cycle pulse at each frame boundary

## Operation
- scan_cnt: 0..SCAN_DIV-1; tick when scan_cnt==SCAN_DIV-1, then scan_cnt->0.
- idx: 0..DIGITS-1; on tick increments, wrapping DIGITS-1->0 (frame boundary).
- Buffers: load=1 copies num/point into pending and sets pend_flag. At frame boundary, if pend_flag, pending->active, pend_flag cleared. load on the boundary cycle: inputs go straight to active, pend_flag stays 0. Display uses active only.
- Decode (logical, before polarity): 0-9 standard; A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (g..a, 0=on).
- Leading-zero blank (lz_blank=1): from digit DIGITS-1 downward, each digit with value 0 and point 0 is blanked until first non-blank; digit 0 never blanked.
- Blanked digit: sel still asserted, all segments and dp off.
- en=0: sel all inactive, seg_led all off; counters and buffers keep running.
- Polarity: SEL_ACTIVE_LOW/SEG_ACTIVE_LOW invert physical outputs; exactly one sel bit active when en=1.

## Timing
- Reset: scan_cnt=0, idx=0, active/pending=0, pend_flag=0, blink phase=0; sel all inactive (all ones for active-low), seg_led all off (8'hFF active-low), frame_done=0.
- idx changes the cycle after tick; sel/seg_led reflect new idx one cycle later (1-cycle registered latency). First post-reset cycle outputs digit 0.
- frame_done asserts the cycle idx becomes 0; period DIGITS*SCAN_DIV.
- Active-buffer change is visible only from digit 0 of a frame; never mid-frame.
- Reset asserted mid-frame: all state returns to reset values immediately; pending value discarded.

## Configuration
- SEG_BLINK_EN defined: frame counter 0..BLINK_DIV-1 toggles blink phase at wrap; while phase=1 digits with blink bit set are blanked (sel asserted, segments off).
- Undefined: blink port present but ignored, no frame counter, phase constant 0.

## Test plan
- Reset, defaults with SCAN_DIV=4: during and after rst_n low -> sel=6'h3F, seg_led=8'hFF, frame_done=0; first cycle after release sel=6'b111110.
- load num=24'h123456, point=6'b000100 -> from next frame: digit0 sel=6'b111110 seg=8'h82; digit2 sel=6'b111011 seg=8'h19.
- lz_blank=1, num=24'h000070, point=0 -> digits 5..2 seg=8'hFF, digit1 seg=8'hF8, digit0 seg=8'hC0; num=0 -> only digit0 shows 8'hC0.
- num nibble 4'hF with dp off -> seg=8'h8E; en=0 -> sel=6'h3F, seg=8'hFF, frame_done still every 24 cycles.
- load mid-frame (idx=3) -> old value until frame_done, new value from digit 0; load on boundary cycle -> new value in that frame.
- SEG_BLINK_EN, BLINK_DIV=2, blink=6'b001000 -> digit3 dark for 2 frames of every 4; others unaffected; macro undefined -> digit3 never dark.
